program_memory_loader: RTL and testbench

Controller that owns the single port of the instruction memory and shares it between instruction fetch and a word-stream program loader. In normal operation it passes the core's fetch address through to the memory, as a word index, and returns the instruction combinationally. On a load request it stalls the core and writes a counted block of words from address 0. When the block is complete it pulses a core restart so execution begins from the newly loaded image.

---
 rtl/program_memory_loader_pkg.sv | 21 ++
 rtl/program_memory_loader_load_counter.sv | 51 +++++
 rtl/program_memory_loader.sv | 127 ++++++++++++
 tb/tb_program_memory_loader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/program_memory_loader_pkg.sv
// Shared definitions for the program memory loader and its neighbours.
// Holds the controller state encoding, the stall NOP and the fetch index helper.
// No logic of its own; imported by the loader, decoder and other controllers.
package program_memory_loader_pkg;

  // Controller states: normal fetch, block load, one-cycle core restart
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LOAD    = 2'd1,
    RESTART = 2'd2
  } state_e;

  // addi x0, x0, 0 -- fed to decode whenever the core is held
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // Byte address from the PC to a word index; callers truncate to their depth
  function automatic logic [31:0] byte_to_word(input logic [31:0] byte_addr);
    return {2'b00, byte_addr[31:2]};
  endfunction

endpackage

// File: rtl/program_memory_loader_load_counter.sv
// Write pointer and remaining-word count for one program load block.
// Registered; pointer/count update on the edge after load_i or inc_i.
// No backpressure of its own; the caller only asserts inc_i on accepted words.
module load_counter
  import program_memory_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH:0]   count_i,
  input  logic                  inc_i,
  output logic [ADDR_WIDTH-1:0] ptr_o,
  output logic                  last_o
);

  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;

  // A full-depth load finishes on the top index, so the pointer holds
  // rather than wrapping back to 0 on the final word.
  always_comb begin
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    if (load_i) begin
      ptr_d       = '0;
      remaining_d = count_i;
    end else if (inc_i) begin
      remaining_d = remaining_q - 1'b1;
      if (!last_o) begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  // Pointer and count registers, cleared by synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q       <= '0;
      remaining_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
    end
  end

  assign ptr_o  = ptr_q;
  assign last_o = (remaining_q == {{ADDR_WIDTH{1'b0}}, 1'b1});

endmodule

// File: rtl/program_memory_loader.sv
// Shares the instruction memory port between core fetch and a word-stream loader.
// Fetch is combinational (zero latency); loads write one word per cycle, then restart.
// Core is stalled during LOAD/RESTART; loader backpressure is Load_Ready_o (high in LOAD).
module program_memory_loader
  import program_memory_loader_pkg::*;
#(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          Load_Start_i,
  input  logic [$clog2(MEMORY_DEPTH):0] Load_Count_i,
  input  logic                          Load_Abort_i,
  input  logic                          Load_Valid_i,
  input  logic [DATA_WIDTH-1:0]         Load_Data_i,
  output logic                          Load_Ready_o,
  output logic                          Load_Done_o,
  output logic                          Load_Error_o,
  input  logic [DATA_WIDTH-1:0]         Fetch_Address_i,
  output logic [DATA_WIDTH-1:0]         Fetch_Instruction_o,
  output logic                          Core_Stall_o,
  output logic                          Core_Restart_o,
  output logic                          Mem_Write_Enable_o,
  output logic [$clog2(MEMORY_DEPTH)-1:0] Mem_Address_o,
  output logic [DATA_WIDTH-1:0]         Mem_Write_Data_o,
  input  logic [DATA_WIDTH-1:0]         Mem_Read_Data_i
);

  localparam int ADDR_WIDTH = $clog2(MEMORY_DEPTH);
  localparam int CNT_WIDTH  = ADDR_WIDTH + 1;

  state_e                state_q, state_d;
  logic                  error_q, error_d;
  logic                  aborted_q, aborted_d;
  logic                  cnt_load, cnt_inc, cnt_last;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic                  count_ok;

  load_counter #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_load_counter (
    .clk_i   (clk),
    .reset_i (reset),
    .load_i  (cnt_load),
    .count_i (Load_Count_i),
    .inc_i   (cnt_inc),
    .ptr_o   (wr_ptr),
    .last_o  (cnt_last)
  );

  assign count_ok = (Load_Count_i != '0) &&
                    (Load_Count_i <= CNT_WIDTH'(MEMORY_DEPTH));

  // Next-state and memory-port mux; abort outranks a word arriving the same cycle
  always_comb begin
    state_d             = state_q;
    error_d             = 1'b0;
    aborted_d           = aborted_q;
    cnt_load            = 1'b0;
    cnt_inc             = 1'b0;
    Load_Ready_o        = 1'b0;
    Core_Stall_o        = 1'b0;
    Mem_Write_Enable_o  = 1'b0;
    Mem_Address_o       = '0;
    Fetch_Instruction_o = '0;
    case (state_q)
      RUN: begin
        Mem_Address_o       = ADDR_WIDTH'(byte_to_word(32'(Fetch_Address_i)));
        Fetch_Instruction_o = Mem_Read_Data_i;
        if (Load_Start_i) begin
          if (count_ok) begin
            cnt_load  = 1'b1;
            aborted_d = 1'b0;
            state_d   = LOAD;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      LOAD: begin
        Core_Stall_o        = 1'b1;
        Fetch_Instruction_o = DATA_WIDTH'(NOP_WORD);
        Load_Ready_o        = 1'b1;
        Mem_Address_o       = wr_ptr;
        if (Load_Abort_i) begin
          error_d   = 1'b1;
          aborted_d = 1'b1;
          state_d   = RESTART;
        end else if (Load_Valid_i) begin
          Mem_Write_Enable_o = 1'b1;
          cnt_inc            = 1'b1;
          if (cnt_last) begin
            state_d = RESTART;
          end
        end
      end
      RESTART: begin
        Core_Stall_o        = 1'b1;
        Fetch_Instruction_o = DATA_WIDTH'(NOP_WORD);
        state_d             = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State and status-pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      error_q   <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      error_q   <= error_d;
      aborted_q <= aborted_d;
    end
  end

  assign Core_Restart_o   = (state_q == RESTART);
  assign Load_Done_o      = (state_q == RESTART) && !aborted_q;
  assign Load_Error_o     = error_q;
  assign Mem_Write_Data_o = Load_Data_i;

endmodule

// File: tb/tb_program_memory_loader.sv
// Directed bench for program_memory_loader with a behavioural async-read memory.
module tb_program_memory_loader;

  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          reset;
  logic          Load_Start_i;
  logic [AW:0]   Load_Count_i;
  logic          Load_Abort_i;
  logic          Load_Valid_i;
  logic [31:0]   Load_Data_i;
  logic          Load_Ready_o;
  logic          Load_Done_o;
  logic          Load_Error_o;
  logic [31:0]   Fetch_Address_i;
  logic [31:0]   Fetch_Instruction_o;
  logic          Core_Stall_o;
  logic          Core_Restart_o;
  logic          Mem_Write_Enable_o;
  logic [AW-1:0] Mem_Address_o;
  logic [31:0]   Mem_Write_Data_o;
  logic [31:0]   Mem_Read_Data_i;

  logic [31:0]   mem [DEPTH];
  logic          poke_vld;
  logic [AW-1:0] poke_addr;
  logic [31:0]   poke_dat;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  program_memory_loader #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(32)) dut (
    .clk                 (clk),
    .reset               (reset),
    .Load_Start_i        (Load_Start_i),
    .Load_Count_i        (Load_Count_i),
    .Load_Abort_i        (Load_Abort_i),
    .Load_Valid_i        (Load_Valid_i),
    .Load_Data_i         (Load_Data_i),
    .Load_Ready_o        (Load_Ready_o),
    .Load_Done_o         (Load_Done_o),
    .Load_Error_o        (Load_Error_o),
    .Fetch_Address_i     (Fetch_Address_i),
    .Fetch_Instruction_o (Fetch_Instruction_o),
    .Core_Stall_o        (Core_Stall_o),
    .Core_Restart_o      (Core_Restart_o),
    .Mem_Write_Enable_o  (Mem_Write_Enable_o),
    .Mem_Address_o       (Mem_Address_o),
    .Mem_Write_Data_o    (Mem_Write_Data_o),
    .Mem_Read_Data_i     (Mem_Read_Data_i)
  );

  // Memory model: bench pokes for preload, DUT writes otherwise
  always @(posedge clk) begin
    if (poke_vld) mem[poke_addr] <= poke_dat;
    else if (Mem_Write_Enable_o) mem[Mem_Address_o] <= Mem_Write_Data_o;
  end
  assign Mem_Read_Data_i = mem[Mem_Address_o];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [31:0] d);
    poke_vld = 1'b1; poke_addr = a; poke_dat = d;
    tick();
    poke_vld = 1'b0;
  endtask

  task automatic start(input logic [AW:0] cnt);
    Load_Start_i = 1'b1; Load_Count_i = cnt;
    tick();
    Load_Start_i = 1'b0;
  endtask

  // Drives one cycle of the loader stream and checks the write strobe/address
  task automatic word(input string tag, input logic vld, input logic [31:0] d,
                      input logic exp_we, input logic [AW-1:0] exp_addr);
    Load_Valid_i = vld; Load_Data_i = d;
    #1;
    check({tag, "_we"}, 32'(Mem_Write_Enable_o), 32'(exp_we));
    if (exp_we) begin
      check({tag, "_addr"}, 32'(Mem_Address_o), 32'(exp_addr));
      check({tag, "_wdat"}, Mem_Write_Data_o, d);
    end
    tick();
    Load_Valid_i = 1'b0;
  endtask

  logic [31:0] b2b_words [4];
  logic        gap_vld   [7];
  int          ready_cycles;

  initial begin
    b2b_words = '{32'h11, 32'h22, 32'h33, 32'h44};
    gap_vld   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    reset = 1'b1; Load_Start_i = 1'b0; Load_Count_i = '0; Load_Abort_i = 1'b0;
    Load_Valid_i = 1'b0; Load_Data_i = '0; Fetch_Address_i = '0;
    poke_vld = 1'b0; poke_addr = '0; poke_dat = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_stall",   32'(Core_Stall_o),   0);
    check("rst_ready",   32'(Load_Ready_o),   0);
    check("rst_done",    32'(Load_Done_o),    0);
    check("rst_error",   32'(Load_Error_o),   0);
    check("rst_restart", 32'(Core_Restart_o), 0);

    // Combinational fetch, including aliasing of upper address bits
    poke(5'd3, 32'hABCD_0123);
    Fetch_Address_i = 32'h0000_000C; #1;
    check("fetch_idx",   32'(Mem_Address_o), 3);
    check("fetch_instr", Fetch_Instruction_o, 32'hABCD_0123);
    Fetch_Address_i = 32'h0000_008C; #1;
    check("fetch_alias", Fetch_Instruction_o, 32'hABCD_0123);
    Fetch_Address_i = '0;

    // 4-word back-to-back load
    start(6'd4);
    check("b2b_stall", 32'(Core_Stall_o), 1);
    check("b2b_ready", 32'(Load_Ready_o), 1);
    check("b2b_nop",   Fetch_Instruction_o, NOP);
    for (int i = 0; i < 4; i++) word("b2b", 1'b1, b2b_words[i], 1'b1, AW'(i));
    check("b2b_restart", 32'(Core_Restart_o), 1);
    check("b2b_done",    32'(Load_Done_o),    1);
    check("b2b_error",   32'(Load_Error_o),   0);
    check("b2b_rs_nop",  Fetch_Instruction_o, NOP);
    tick();
    check("b2b_run_stall",   32'(Core_Stall_o),   0);
    check("b2b_run_restart", 32'(Core_Restart_o), 0);
    check("b2b_run_done",    32'(Load_Done_o),    0);
    check("b2b_fetch0",      Fetch_Instruction_o, 32'h11);
    for (int i = 0; i < 4; i++) check("b2b_mem", mem[i], b2b_words[i]);

    // Same load with a 3-cycle gap after word 2
    for (int i = 0; i < 4; i++) poke(AW'(i), 32'h0);
    start(6'd4);
    begin
      int w;
      w = 0;
      ready_cycles = 0;
      for (int c = 0; c < 7; c++) begin
        ready_cycles += int'(Load_Ready_o);
        word("gap", gap_vld[c], gap_vld[c] ? b2b_words[w] : 32'hDEAD_BEEF,
             gap_vld[c], AW'(w));
        if (gap_vld[c]) w++;
      end
    end
    check("gap_load_cycles", 32'(ready_cycles), 7);
    check("gap_restart", 32'(Core_Restart_o), 1);
    check("gap_done",    32'(Load_Done_o),    1);
    tick();
    for (int i = 0; i < 4; i++) check("gap_mem", mem[i], b2b_words[i]);

    // Bad counts: 0 and DEPTH+1
    Load_Start_i = 1'b1; Load_Count_i = 6'd0; #1;
    check("cnt0_we", 32'(Mem_Write_Enable_o), 0);
    tick(); Load_Start_i = 1'b0;
    check("cnt0_error", 32'(Load_Error_o), 1);
    check("cnt0_stall", 32'(Core_Stall_o), 0);
    check("cnt0_ready", 32'(Load_Ready_o), 0);
    tick();
    check("cnt0_pulse", 32'(Load_Error_o), 0);
    Load_Start_i = 1'b1; Load_Count_i = 6'd33; #1;
    check("cnt33_we", 32'(Mem_Write_Enable_o), 0);
    tick(); Load_Start_i = 1'b0;
    check("cnt33_error", 32'(Load_Error_o), 1);
    check("cnt33_stall", 32'(Core_Stall_o), 0);
    tick();
    check("cnt33_pulse", 32'(Load_Error_o), 0);
    check("cnt33_ready", 32'(Load_Ready_o), 0);

    // Abort with a valid third word of a 5-word load
    start(6'd5);
    word("abt", 1'b1, 32'hA1, 1'b1, 5'd0);
    word("abt", 1'b1, 32'hA2, 1'b1, 5'd1);
    Load_Abort_i = 1'b1;
    word("abt3", 1'b1, 32'hA3, 1'b0, 5'd2);
    Load_Abort_i = 1'b0;
    check("abt_restart", 32'(Core_Restart_o), 1);
    check("abt_error",   32'(Load_Error_o),   1);
    check("abt_done",    32'(Load_Done_o),    0);
    tick();
    check("abt_run_error", 32'(Load_Error_o), 0);
    check("abt_run_stall", 32'(Core_Stall_o), 0);
    check("abt_mem0", mem[0], 32'hA1);
    check("abt_mem2", mem[2], 32'h33);

    // Load_Start_i during LOAD is ignored: a 3-word load still takes 3 words
    start(6'd3);
    word("ign", 1'b1, 32'hB1, 1'b1, 5'd0);
    Load_Start_i = 1'b1; Load_Count_i = 6'd1;
    word("ign", 1'b1, 32'hB2, 1'b1, 5'd1);
    Load_Start_i = 1'b0;
    check("ign_still_load", 32'(Load_Ready_o),   1);
    check("ign_no_restart", 32'(Core_Restart_o), 0);
    word("ign", 1'b1, 32'hB3, 1'b1, 5'd2);
    check("ign_restart", 32'(Core_Restart_o), 1);
    check("ign_done",    32'(Load_Done_o),    1);
    tick();

    // Reset mid-load
    start(6'd4);
    word("rml", 1'b1, 32'hC1, 1'b1, 5'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rml_stall",   32'(Core_Stall_o),   0);
    check("rml_ready",   32'(Load_Ready_o),   0);
    check("rml_restart", 32'(Core_Restart_o), 0);
    check("rml_done",    32'(Load_Done_o),    0);
    check("rml_error",   32'(Load_Error_o),   0);
    check("rml_mem0",    mem[0], 32'hC1);
    tick();
    check("rml_restart2", 32'(Core_Restart_o), 0);

    // Full-depth load ends on the top index
    start(6'd32);
    for (int i = 0; i < DEPTH; i++) word("full", 1'b1, 32'h5A00_0000 + 32'(i), 1'b1, AW'(i));
    check("full_restart", 32'(Core_Restart_o), 1);
    check("full_done",    32'(Load_Done_o),    1);
    tick();
    Fetch_Address_i = 32'h0000_007C; #1;
    check("full_fetch31", Fetch_Instruction_o, 32'h5A00_001F);
    Fetch_Address_i = 32'h0000_0000; #1;
    check("full_fetch0",  Fetch_Instruction_o, 32'h5A00_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
